// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD card access arbiter and its helpers.
package sd_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP,
        S_DRAIN,
        S_FINISH
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_RD   = 2'd1;
    localparam logic [1:0] OWN_WR   = 2'd2;

    typedef enum logic [1:0] {
        UNKNOWN,
        SDv1,
        SDv2,
        SDHCv2
    } card_type_t;

endpackage

// File: rtl/sd_watchdog.sv
// Saturating 24-bit cycle counter; expired is high once the count reaches TIMEOUT_CYCLES.
module sd_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [23:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 24'd1;
        end
    end

    assign expired = ({8'd0, count} >= TIMEOUT_CYCLES);

endmodule

// File: rtl/sd_access_arbiter.sv
// Round-robin owner of one SD card shared by a sector reader and a sector writer:
// sequences the engines, retries failed/timed-out attempts and muxes the SD pins.
module sd_access_arbiter
    import sd_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4_000_000,
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned RETRY_GAP      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        card_ready,
    input  logic        rd_req,
    input  logic [31:0] rd_sector,
    output logic        rd_done,
    output logic        rd_err,
    input  logic        wr_req,
    input  logic [31:0] wr_sector,
    output logic        wr_done,
    output logic        wr_err,
    output logic        eng_rstart,
    output logic        eng_wstart,
    output logic [31:0] eng_sector,
    input  logic        rd_eng_busy,
    input  logic        rd_eng_done,
    input  logic        rd_eng_ok,
    input  logic        wr_eng_busy,
    input  logic        wr_eng_done,
    input  logic        wr_eng_ok,
    input  logic        rd_sdclk,
    input  logic        rd_sdcmdout,
    input  logic        rd_sdcmdoe,
    input  logic        rd_d0_dir,
    input  logic        wr_sdclk,
    input  logic        wr_sdcmdout,
    input  logic        wr_sdcmdoe,
    input  logic        wr_d0_dir,
    output logic        sdclk,
    output logic        sdcmdout,
    output logic        sdcmdoe,
    output logic        SD_CMD_DIR,
    output logic        SD_D0_DIR,
    output logic [1:0]  owner
);

    arb_state_t  state;
    logic        last_wr;
    logic        failed;
    logic [2:0]  retry_cnt;
    logic [15:0] gap_cnt;
    logic        wd_expired;
    logic        sel_done;
    logic        sel_ok;
    logic        sel_busy;
    logic        retry_left;
    logic        gap_last;

    sd_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == S_START),
        .enable (state == S_WAIT),
        .expired(wd_expired)
    );

    assign sel_done   = (owner == OWN_WR) ? wr_eng_done : rd_eng_done;
    assign sel_ok     = (owner == OWN_WR) ? wr_eng_ok   : rd_eng_ok;
    assign sel_busy   = (owner == OWN_WR) ? wr_eng_busy : rd_eng_busy;
    assign retry_left = ({29'd0, retry_cnt} < MAX_RETRY);
    assign gap_last   = (({16'd0, gap_cnt} + 32'd1) >= RETRY_GAP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_wr    <= 1'b1;
            failed     <= 1'b0;
            retry_cnt  <= '0;
            gap_cnt    <= '0;
            owner      <= OWN_NONE;
            eng_sector <= '0;
            eng_rstart <= 1'b0;
            eng_wstart <= 1'b0;
            rd_done    <= 1'b0;
            rd_err     <= 1'b0;
            wr_done    <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            eng_rstart <= 1'b0;
            eng_wstart <= 1'b0;
            rd_done    <= 1'b0;
            rd_err     <= 1'b0;
            wr_done    <= 1'b0;
            wr_err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (card_ready && (rd_req || wr_req)) begin
                        // A lone request wins outright; a tie goes to the side not served last.
                        if (rd_req && (!wr_req || last_wr)) begin
                            owner      <= OWN_RD;
                            eng_sector <= rd_sector;
                        end else begin
                            owner      <= OWN_WR;
                            eng_sector <= wr_sector;
                        end
                        state <= S_START;
                    end
                end
                S_START: begin
                    eng_rstart <= (owner == OWN_RD);
                    eng_wstart <= (owner == OWN_WR);
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (sel_done) begin
                        if (sel_ok) begin
                            failed <= 1'b0;
                            state  <= S_FINISH;
                        end else if (retry_left) begin
                            retry_cnt <= retry_cnt + 3'd1;
                            gap_cnt   <= '0;
                            state     <= S_GAP;
                        end else begin
                            failed <= 1'b1;
                            state  <= S_FINISH;
                        end
                    end else if (wd_expired) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!sel_busy) begin
                        if (retry_left) begin
                            retry_cnt <= retry_cnt + 3'd1;
                            gap_cnt   <= '0;
                            state     <= S_GAP;
                        end else begin
                            failed <= 1'b1;
                            state  <= S_FINISH;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_last) begin
                        state <= S_START;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                S_FINISH: begin
                    rd_done   <= (owner == OWN_RD);
                    wr_done   <= (owner == OWN_WR);
                    rd_err    <= failed && (owner == OWN_RD);
                    wr_err    <= failed && (owner == OWN_WR);
                    last_wr   <= (owner == OWN_WR);
                    owner     <= OWN_NONE;
                    retry_cnt <= '0;
                    failed    <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // CMD direction follows the owning engine's CMD output enable.
    always_comb begin
        sdclk      = 1'b0;
        sdcmdout   = 1'b1;
        sdcmdoe    = 1'b0;
        SD_CMD_DIR = 1'b0;
        SD_D0_DIR  = 1'b0;
        case (owner)
            OWN_RD: begin
                sdclk      = rd_sdclk;
                sdcmdout   = rd_sdcmdout;
                sdcmdoe    = rd_sdcmdoe;
                SD_CMD_DIR = rd_sdcmdoe;
                SD_D0_DIR  = rd_d0_dir;
            end
            OWN_WR: begin
                sdclk      = wr_sdclk;
                sdcmdout   = wr_sdcmdout;
                sdcmdoe    = wr_sdcmdoe;
                SD_CMD_DIR = wr_sdcmdoe;
                SD_D0_DIR  = wr_d0_dir;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Directed and randomized bench for sd_access_arbiter; the bench plays both engines and requesters.
module tb_sd_access_arbiter;

    localparam int unsigned T  = 1000;
    localparam int unsigned MR = 2;
    localparam int unsigned G  = 8;
    localparam int K_OK     = 0;
    localparam int K_FAIL   = 1;
    localparam int K_SILENT = 2;
    localparam int K_HANG   = 3;

    logic        clk = 1'b0;
    logic        rst_n, card_ready, rd_req, wr_req;
    logic [31:0] rd_sector, wr_sector, eng_sector;
    logic        rd_done, rd_err, wr_done, wr_err, eng_rstart, eng_wstart;
    logic        rd_eng_busy, rd_eng_done, rd_eng_ok;
    logic        wr_eng_busy, wr_eng_done, wr_eng_ok;
    logic        rd_sdclk, rd_sdcmdout, rd_sdcmdoe, rd_d0_dir;
    logic        wr_sdclk, wr_sdcmdout, wr_sdcmdoe, wr_d0_dir;
    logic        sdclk, sdcmdout, sdcmdoe, SD_CMD_DIR, SD_D0_DIR;
    logic [1:0]  owner;

    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          last_wr = 1'b1;
    bit          blip = 1'b0;
    int          plan_kind [8];
    int          plan_lat [8];
    int unsigned first_pcyc = 0;

    sd_access_arbiter #(
        .TIMEOUT_CYCLES(T),
        .MAX_RETRY     (MR),
        .RETRY_GAP     (G)
    ) dut (
        .clk(clk), .rst_n(rst_n), .card_ready(card_ready),
        .rd_req(rd_req), .rd_sector(rd_sector), .rd_done(rd_done), .rd_err(rd_err),
        .wr_req(wr_req), .wr_sector(wr_sector), .wr_done(wr_done), .wr_err(wr_err),
        .eng_rstart(eng_rstart), .eng_wstart(eng_wstart), .eng_sector(eng_sector),
        .rd_eng_busy(rd_eng_busy), .rd_eng_done(rd_eng_done), .rd_eng_ok(rd_eng_ok),
        .wr_eng_busy(wr_eng_busy), .wr_eng_done(wr_eng_done), .wr_eng_ok(wr_eng_ok),
        .rd_sdclk(rd_sdclk), .rd_sdcmdout(rd_sdcmdout), .rd_sdcmdoe(rd_sdcmdoe), .rd_d0_dir(rd_d0_dir),
        .wr_sdclk(wr_sdclk), .wr_sdcmdout(wr_sdcmdout), .wr_sdcmdoe(wr_sdcmdoe), .wr_d0_dir(wr_d0_dir),
        .sdclk(sdclk), .sdcmdout(sdcmdout), .sdcmdoe(sdcmdoe),
        .SD_CMD_DIR(SD_CMD_DIR), .SD_D0_DIR(SD_D0_DIR), .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic chk_range(input string tag, input int unsigned v, input int unsigned lo, input int unsigned hi);
        vectors++;
        assert (v >= lo && v <= hi) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d..%0d", tag, v, lo, hi);
        end
    endtask

    task automatic check_pins(input logic [1:0] own, input string tag);
        logic [3:0] r;
        logic [3:0] w;
        logic [4:0] want;
        r = 4'($urandom);
        w = 4'($urandom);
        {rd_sdclk, rd_sdcmdout, rd_sdcmdoe, rd_d0_dir} = r;
        {wr_sdclk, wr_sdcmdout, wr_sdcmdoe, wr_d0_dir} = w;
        #1;
        if (own == 2'd1)      want = {r[3], r[2], r[1], r[1], r[0]};
        else if (own == 2'd2) want = {w[3], w[2], w[1], w[1], w[0]};
        else                  want = 5'b01000;
        chk(tag, 32'({sdclk, sdcmdout, sdcmdoe, SD_CMD_DIR, SD_D0_DIR}), 32'(want));
    endtask

    task automatic set_busy(input bit wr, input bit v);
        if (wr) wr_eng_busy = v;
        else    rd_eng_busy = v;
    endtask

    task automatic set_done(input bit wr, input bit d, input bit ok);
        if (wr) {wr_eng_done, wr_eng_ok} = {d, ok};
        else    {rd_eng_done, rd_eng_ok} = {d, ok};
    endtask

    task automatic fill_plan(input int k, input int lat);
        for (int i = 0; i < 8; i++) begin
            plan_kind[i] = k;
            plan_lat[i]  = lat;
        end
    endtask

    task automatic rand_plan();
        int r;
        for (int i = 0; i < 8; i++) begin
            r = int'($urandom_range(0, 15));
            plan_kind[i] = (r < 11) ? K_OK : (r < 15) ? K_FAIL : K_SILENT;
            plan_lat[i]  = int'($urandom_range(1, 30));
        end
    endtask

    task automatic wait_pulse(output bit got, output int unsigned pc);
        got = 1'b0;
        pc  = 0;
        for (int i = 0; i < int'(T + G + 60); i++) begin
            tick();
            if (eng_rstart || eng_wstart) begin
                got = 1'b1;
                pc  = cyc;
                break;
            end
        end
        if (!got) chk("start_pulse_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(output bit got, output int unsigned dc);
        got = 1'b0;
        dc  = 0;
        for (int i = 0; i < int'(T + G + 60); i++) begin
            tick();
            if (rd_done || wr_done) begin
                got = 1'b1;
                dc  = cyc;
                break;
            end
        end
        if (!got) chk("user_done_timeout", 32'd0, 32'd1);
    endtask

    // mode 0: drop req at done, 1: keep req held, 2: drop req right after the first start pulse
    task automatic serve_op(input bit wr, input logic [31:0] sec, input int mode);
        int          attempts;
        bit          exp_err;
        bit          got;
        int unsigned pc, ref_c, dc, lo, hi, dlo, dhi;
        attempts = int'(MR) + 1;
        exp_err  = 1'b1;
        for (int i = 0; i <= int'(MR); i++) begin
            if (plan_kind[i] == K_OK) begin
                attempts = i + 1;
                exp_err  = 1'b0;
                break;
            end
        end
        ref_c = 0; lo = 0; hi = 0; dlo = 0; dhi = 0;
        for (int a = 0; a < attempts; a++) begin
            wait_pulse(got, pc);
            if (!got) return;
            if (a == 0) first_pcyc = pc;
            else chk_range("retry_spacing", pc - ref_c, lo, hi);
            chk("start_side", 32'({eng_rstart, eng_wstart}), wr ? 32'd1 : 32'd2);
            chk("eng_sector", eng_sector, sec);
            chk("owner_granted", 32'(owner), wr ? 32'd2 : 32'd1);
            check_pins(wr ? 2'd2 : 2'd1, "pins_owned");
            if (mode == 2) begin
                if (wr) wr_req = 1'b0;
                else    rd_req = 1'b0;
            end
            tick();
            chk("start_one_cycle", 32'({eng_rstart, eng_wstart}), 32'd0);
            set_busy(wr, 1'b1);
            if (blip) card_ready = 1'b0;
            case (plan_kind[a])
                K_SILENT: begin
                    // busy falls early with no done: watchdog expiry, then drain sees idle engine
                    repeat (plan_lat[a]) tick();
                    set_busy(wr, 1'b0);
                    ref_c = pc;
                    lo = T + G + 2; hi = T + G + 4;
                    dlo = T + 2;    dhi = T + 4;
                end
                K_HANG: begin
                    repeat (T + 20) tick();
                    set_busy(wr, 1'b0);
                    tick();
                    ref_c = cyc;
                    lo = G + 1; hi = G + 1; dlo = 1; dhi = 1;
                end
                default: begin
                    repeat (plan_lat[a] - 1) tick();
                    set_done(wr, 1'b1, plan_kind[a] == K_OK);
                    tick();
                    ref_c = cyc;
                    set_done(wr, 1'b0, 1'b0);
                    set_busy(wr, 1'b0);
                    lo = G + 1; hi = G + 1; dlo = 1; dhi = 1;
                end
            endcase
        end
        wait_done(got, dc);
        card_ready = 1'b1;
        if (!got) return;
        chk_range("done_latency", dc - ref_c, dlo, dhi);
        chk("done_side", 32'({rd_done, wr_done}), wr ? 32'd1 : 32'd2);
        chk("err", 32'(wr ? wr_err : rd_err), 32'(exp_err));
        chk("owner_released", 32'(owner), 32'd0);
        check_pins(2'd0, "pins_safe");
        last_wr = wr;
        if (mode != 1) begin
            if (wr) wr_req = 1'b0;
            else    rd_req = 1'b0;
        end
        tick();
        chk("done_one_cycle", 32'({rd_done, wr_done, rd_err, wr_err}), 32'd0);
    endtask

    initial begin
        bit          got;
        bit          saw;
        bit          first_wr;
        bit [1:0]    pat;
        int          md;
        int          pulses;
        int unsigned pc, c0;
        logic [31:0] rs, ws;

        rst_n = 1'b0; card_ready = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        rd_sector = '0; wr_sector = '0;
        {rd_eng_busy, rd_eng_done, rd_eng_ok, wr_eng_busy, wr_eng_done, wr_eng_ok} = '0;
        {rd_sdclk, rd_sdcmdout, rd_sdcmdoe, rd_d0_dir} = '0;
        {wr_sdclk, wr_sdcmdout, wr_sdcmdoe, wr_d0_dir} = '0;
        repeat (3) tick();
        chk("reset_outputs", 32'({rd_done, rd_err, wr_done, wr_err, eng_rstart, eng_wstart}), 32'd0);
        chk("reset_owner", 32'(owner), 32'd0);
        chk("reset_sector", eng_sector, 32'd0);
        check_pins(2'd0, "reset_pins");
        rst_n = 1'b1;
        tick();

        // tie after reset: reader first, then strict alternation while both stay requested
        fill_plan(K_OK, 5);
        rd_sector = 32'h100; wr_sector = 32'h200;
        rd_req = 1'b1; wr_req = 1'b1;
        serve_op(1'b0, 32'h100, 1);
        serve_op(1'b1, 32'h200, 1);
        serve_op(1'b0, 32'h100, 1);
        rd_req = 1'b0;
        serve_op(1'b1, 32'h200, 0);

        // single read, engine ok after 100 cycles
        fill_plan(K_OK, 100);
        rd_sector = 32'h10; rd_req = 1'b1; c0 = cyc;
        serve_op(1'b0, 32'h10, 0);
        chk("grant_latency", first_pcyc - c0, 32'd2);

        // write fails every attempt
        fill_plan(K_FAIL, 20);
        wr_sector = 32'hABCD; wr_req = 1'b1;
        serve_op(1'b1, 32'hABCD, 0);

        // watchdog: hang, silent busy drop, then failing done
        plan_kind[0] = K_HANG;   plan_lat[0] = 1;
        plan_kind[1] = K_SILENT; plan_lat[1] = 50;
        plan_kind[2] = K_FAIL;   plan_lat[2] = 10;
        rd_sector = 32'hDEAD_0001; rd_req = 1'b1;
        serve_op(1'b0, 32'hDEAD_0001, 0);

        // requester drops mid-operation; card_ready blips low during the attempt
        fill_plan(K_OK, 40);
        plan_kind[0] = K_FAIL;
        blip = 1'b1;
        wr_sector = 32'h0000_0F0F; wr_req = 1'b1;
        serve_op(1'b1, 32'h0000_0F0F, 2);
        blip = 1'b0;

        // engine done while idle is ignored
        {rd_eng_done, rd_eng_ok, wr_eng_done, wr_eng_ok} = 4'b1110;
        tick();
        {rd_eng_done, rd_eng_ok, wr_eng_done, wr_eng_ok} = 4'b0000;
        tick();
        chk("spurious_done_a", 32'({rd_done, wr_done, rd_err, wr_err, eng_rstart, eng_wstart}), 32'd0);
        tick();
        chk("spurious_done_b", 32'({rd_done, wr_done, rd_err, wr_err, eng_rstart, eng_wstart}), 32'd0);

        // card not ready blocks the grant
        card_ready = 1'b0;
        rd_sector = 32'h55; rd_req = 1'b1;
        pulses = 0;
        repeat (500) begin
            tick();
            if (eng_rstart || eng_wstart) pulses++;
        end
        chk("no_grant_not_ready", 32'(pulses), 32'd0);
        fill_plan(K_OK, 8);
        card_ready = 1'b1; c0 = cyc;
        serve_op(1'b0, 32'h55, 0);
        chk("ready_grant_latency", first_pcyc - c0, 32'd2);

        // reset during a write's WAIT
        wr_sector = 32'h5A5A; wr_req = 1'b1;
        wait_pulse(got, pc);
        chk("rst_test_side", 32'({eng_rstart, eng_wstart}), 32'd1);
        tick();
        set_busy(1'b1, 1'b1);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_owner", 32'(owner), 32'd0);
        chk("midrst_outputs", 32'({rd_done, rd_err, wr_done, wr_err, eng_rstart, eng_wstart}), 32'd0);
        chk("midrst_sector", eng_sector, 32'd0);
        check_pins(2'd0, "midrst_pins");
        wr_req = 1'b0;
        set_busy(1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (30) begin
            tick();
            saw = saw | rd_done | wr_done | eng_rstart | eng_wstart;
        end
        chk("midrst_no_done", 32'(saw), 32'd0);
        last_wr = 1'b1;
        fill_plan(K_OK, 12);
        rd_sector = 32'h77; wr_sector = 32'h88;
        rd_req = 1'b1; wr_req = 1'b1;
        serve_op(1'b0, 32'h77, 0);
        serve_op(1'b1, 32'h88, 0);

        // randomized traffic against the round-robin / retry model
        for (int n = 0; n < 24; n++) begin
            pat = 2'($urandom_range(1, 3));
            rs  = $urandom;
            ws  = $urandom;
            rd_sector = rs; wr_sector = ws;
            rand_plan();
            blip = ($urandom_range(0, 3) == 0);
            md   = ($urandom_range(0, 3) == 0) ? 2 : 0;
            rd_req = pat[0];
            wr_req = pat[1];
            if (pat == 2'd3) first_wr = !last_wr;
            else             first_wr = (pat == 2'd2);
            serve_op(first_wr, first_wr ? ws : rs, md);
            blip = 1'b0;
            if (pat == 2'd3) begin
                rand_plan();
                serve_op(!first_wr, first_wr ? rs : ws, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
